// File: rtl/intra_pkg.sv
// Shared constants and helpers for the angular intra-prediction filter paths.
// The clip function maps a signed filtered value to the unsigned sample range.
package intra_pkg;

  localparam int BD     = 8;
  localparam int SHIFT  = 6;
  localparam int ROUND  = 1 << (SHIFT - 1);
  localparam int ROW    = 16;
  localparam int IDX_W  = $clog2(ROW);
  localparam int CNT_W  = IDX_W + 1;
  localparam int SMAX   = (1 << BD) - 1;

  typedef logic [BD-1:0]         sample_t;
  typedef sample_t [ROW-1:0]     row_t;

  function automatic sample_t clip_bd(input logic signed [31:0] v);
    if (v < 0)
      return '0;
    if (v > SMAX)
      return '1;
    return v[BD-1:0];
  endfunction

endpackage

// File: rtl/intra_round_clip.sv
// Combinational round (+ROUND), arithmetic normalisation shift and clip to BD bits.
// Shared by every filter path that needs the same normalisation.
module intra_round_clip
  import intra_pkg::*;
#(
  parameter int IW = 19
) (
  input  logic signed [IW-1:0] sum_i,
  output sample_t              r_o
);

  logic signed [IW:0] sum_ext;
  logic signed [IW:0] rnd;
  logic signed [IW:0] shf;
  logic signed [31:0] shf32;

  // One guard bit keeps the rounding add from wrapping at the positive extreme.
  assign sum_ext = {sum_i[IW-1], sum_i};
  assign rnd     = sum_ext + $signed((IW + 1)'(ROUND));
  assign shf     = rnd >>> SHIFT;
  assign shf32   = {{(32 - IW - 1){shf[IW]}}, shf};
  assign r_o     = clip_bd(shf32);

endmodule

// File: rtl/intra_filter_sum_pack.sv
// Sums four signed tap products per sample, rounds/clips to BD bits and packs
// up to ROW samples per output row; the whole 3-stage pipe freezes on backpressure.
module intra_filter_sum_pack
  import intra_pkg::*;
#(
  parameter int PW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic signed [PW-1:0] p0,
  input  logic signed [PW-1:0] p1,
  input  logic signed [PW-1:0] p2,
  input  logic signed [PW-1:0] p3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROW*BD-1:0]    out_row,
  output logic [4:0]           out_count
);

  localparam int AW = PW + 2;
  localparam int SW = PW + 3;

  logic                 stall;
  logic                 v1_q, last1_q, v2_q, last2_q;
  logic signed [AW-1:0] a_d, b_d, a_q, b_q;
  logic signed [SW-1:0] s_d;
  sample_t              r_d, r_q;
  logic [IDX_W-1:0]     idx_q, idx_d;
  row_t                 lane_q, lane_d, row_q, row_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ov_q, ov_d;

  assign stall     = ov_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = ov_q;
  assign out_row   = row_q;
  assign out_count = cnt_q;

  // S1: pairwise tap sums
  assign a_d = {{(AW - PW){p0[PW-1]}}, p0} + {{(AW - PW){p1[PW-1]}}, p1};
  assign b_d = {{(AW - PW){p2[PW-1]}}, p2} + {{(AW - PW){p3[PW-1]}}, p3};

  // S2: final sum, round, shift, clip
  assign s_d = {a_q[AW-1], a_q} + {b_q[AW-1], b_q};

  intra_round_clip #(.IW(SW)) u_round_clip (
    .sum_i (s_d),
    .r_o   (r_d)
  );

  // S3: lane packing and output row register
  always_comb begin
    lane_d = lane_q;
    idx_d  = idx_q;
    row_d  = row_q;
    cnt_d  = cnt_q;
    ov_d   = ov_q;
    if (!stall) begin
      ov_d = 1'b0;
      if (v2_q) begin
        lane_d[idx_q] = r_q;
        if (idx_q == IDX_W'(ROW - 1) || last2_q) begin
          // Lanes above idx are already zero because the buffer is cleared per row.
          row_d  = lane_d;
          cnt_d  = {1'b0, idx_q} + CNT_W'(1);
          ov_d   = 1'b1;
          idx_d  = '0;
          lane_d = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      idx_q   <= '0;
      lane_q  <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      if (!stall) begin
        v1_q    <= in_valid;
        last1_q <= in_last;
        v2_q    <= v1_q;
        last2_q <= last1_q;
      end
      idx_q  <= idx_d;
      lane_q <= lane_d;
      row_q  <= row_d;
      cnt_q  <= cnt_d;
      ov_q   <= ov_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
    end
  end

endmodule

// File: tb/tb_intra_filter_sum_pack.sv
// Directed + randomized bench for intra_filter_sum_pack against a row-level
// reference model (floor-divide rounding, clip, 16-lane packing with early close).
module tb_intra_filter_sum_pack;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_last = 1'b0;
  logic signed [15:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [127:0]       out_row;
  logic [4:0]         out_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] row;
    int           cnt;
  } row_s;

  row_s exp_q[$];
  row_s mon_e;
  int   lanes[16];
  int   pidx = 0;

  intra_filter_sum_pack #(.PW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .p0        (p0),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Filtered sample: floor((sum + 32) / 64) clipped to 0..255.
  function automatic int ref_sample(input int a, input int b, input int c, input int d);
    int s;
    int q;
    s = a + b + c + d + 32;
    if (s >= 0) q = s / 64;
    else        q = -((-s + 63) / 64);
    if (q < 0)   q = 0;
    if (q > 255) q = 255;
    return q;
  endfunction

  task automatic model_accept(input int a, input int b, input int c, input int d, input bit last);
    row_s r;
    lanes[pidx] = ref_sample(a, b, c, d);
    if (pidx == 15 || last) begin
      r.row = '0;
      for (int i = 0; i <= pidx; i++) r.row[i*8 +: 8] = 8'(lanes[i]);
      r.cnt = pidx + 1;
      exp_q.push_back(r);
      pidx = 0;
    end else begin
      pidx++;
    end
  endtask

  task automatic send(input int a, input int b, input int c, input int d, input bit last);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    in_valid = 1'b1;
    p0 = 16'(a); p1 = 16'(b); p2 = 16'(c); p3 = 16'(d);
    in_last = last;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (acc) model_accept(a, b, c, d, last);
    else     check("send_timeout", 128'(in_ready), 128'(1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int rnd16();
    return int'($signed(16'($urandom)));
  endfunction

  // Output monitor: scoreboard on every transfer, hold check while stalled.
  logic [127:0] prev_row;
  logic [4:0]   prev_cnt;
  bit           prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_row", 128'(out_count), 128'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("row_data", out_row, mon_e.row);
        check("row_count", 128'(out_count), 128'(mon_e.cnt));
      end
      prev_stall = 1'b0;
    end else if (out_valid) begin
      if (prev_stall) begin
        check("stall_row_stable", out_row, prev_row);
        check("stall_cnt_stable", 128'(out_count), 128'(prev_cnt));
      end
      prev_stall = 1'b1;
      prev_row   = out_row;
      prev_cnt   = out_count;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] full64;
    logic [127:0] snap;
    int           n;
    int           ra, rb, rc, rd;

    full64 = {16{8'h64}};

    // Reset
    tick(2);
    rst = 1'b0;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_row", out_row, 128'(0));
    check("rst_out_count", 128'(out_count), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    tick(2);

    // Full row of 100s and 3-cycle latency
    for (int i = 0; i < 16; i++) send(-300, 5300, 1800, -400, 1'b0);
    check("lat_e0", 128'(out_valid), 128'(0));
    tick(1);
    check("lat_e1", 128'(out_valid), 128'(0));
    tick(1);
    check("lat_e2_valid", 128'(out_valid), 128'(1));
    check("full_row", out_row, full64);
    check("full_count", 128'(out_count), 128'(16));
    tick(4);

    // Rounding and clip boundaries, one-sample rows
    send(31, 0, 0, 0, 1'b1);     tick(2);
    check("round_31", 128'(out_row[7:0]), 128'(8'd0));
    check("round_31_cnt", 128'(out_count), 128'(1));
    send(32, 0, 0, 0, 1'b1);     tick(2);
    check("round_32", 128'(out_row[7:0]), 128'(8'd1));
    send(-33, 0, 0, 0, 1'b1);    tick(2);
    check("clip_neg", 128'(out_row[7:0]), 128'(8'd0));
    send(20000, 0, 0, 0, 1'b1);  tick(2);
    check("clip_pos", 128'(out_row[7:0]), 128'(8'd255));
    tick(4);

    // Early close after 5 samples, then next sample starts a new row
    for (int i = 0; i < 5; i++) send(6400, 0, 0, 0, i == 4);
    tick(2);
    check("early_count", 128'(out_count), 128'(5));
    check("early_upper_zero", 128'(out_row[127:40]), 128'(0));
    check("early_lane4", 128'(out_row[39:32]), 128'(8'd100));
    send(12800, 0, 0, 0, 1'b1);  tick(2);
    check("newrow_lane0", 128'(out_row[7:0]), 128'(8'd200));
    check("newrow_count", 128'(out_count), 128'(1));
    tick(4);

    // Backpressure with 40 random samples (16 + 16 + 8)
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          ra = rnd16(); rb = rnd16(); rc = rnd16(); rd = rnd16();
          send(ra, rb, rc, rd, i == 39);
        end
      end
      begin
        n = 0;
        while (!out_valid && n < 500) begin
          @(negedge clk);
          n++;
        end
        snap = out_row;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          check("bp_in_ready_low", 128'(in_ready), 128'(0));
          check("bp_row_hold", out_row, snap);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    tick(8);

    // Back-to-back single-sample rows: out_valid must not bubble
    for (int i = 0; i < 6; i++) send(64 * (i + 1), 0, 0, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("b2b_no_bubble", 128'(out_valid), 128'(1));
      tick(1);
    end
    check("b2b_drained", 128'(out_valid), 128'(0));
    tick(3);

    // Reset mid-row discards partial row and in-flight samples
    for (int i = 0; i < 7; i++) begin
      ra = rnd16(); rb = rnd16(); rc = rnd16(); rd = rnd16();
      send(ra, rb, rc, rd, 1'b0);
    end
    rst  = 1'b1;
    pidx = 0;
    tick(2);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("midrst_no_row", 128'(out_valid), 128'(0));
      tick(1);
    end
    for (int i = 0; i < 16; i++) begin
      ra = rnd16(); rb = rnd16(); rc = rnd16(); rd = rnd16();
      send(ra, rb, rc, rd, 1'b0);
    end
    tick(2);
    check("midrst_clean_valid", 128'(out_valid), 128'(1));
    check("midrst_clean_count", 128'(out_count), 128'(16));

    tick(10);
    check("rows_pending", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
